// File: rtl/div_queue_unit_pkg.sv
// Shared definitions for the queued divide unit: funct3 decode positions,
// divider sequencing states and a leading-zero counter.
package div_queue_unit_pkg;

    localparam int FN3_UNSIGNED_BIT = 0;
    localparam int FN3_REM_BIT      = 1;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    // Leading zeros of a 64-bit value; narrower operands are passed left-aligned.
    function automatic logic [6:0] clz64(input logic [63:0] v);
        logic [6:0] n;
        logic       found;
        n     = 7'd64;
        found = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 7'(63 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/div_queue_unit_iterative_core.sv
// Radix-2 restoring divider on unsigned magnitudes, pre-aligned by CLZ so it
// runs only as many iterations as the quotient has significant bits.
module div_iterative_core
    import div_queue_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CLZ_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [CLZ_W-1:0] dividend_clz,
    input  logic [CLZ_W-1:0] divisor_clz,
    input  logic             divisor_is_zero,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] div_reg;
    logic [WIDTH-2:0] q_reg;
    logic [CLZ_W-1:0] cnt_reg;
    logic [CLZ_W-1:0] align;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // q/r present the values produced by the iteration in flight, so the
    // caller can capture the final result on the same edge as the last step.
    always_comb begin
        align = divisor_clz - dividend_clz;
        diff  = rem_reg - div_reg;
        ge    = (rem_reg >= div_reg);
        q     = {q_reg, ge};
        r     = ge ? diff : rem_reg;
        done  = (cnt_reg == CLZ_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_reg <= '0;
            div_reg <= '0;
            q_reg   <= '0;
            cnt_reg <= '0;
        end else if (abort) begin
            cnt_reg <= '0;
        end else if (start && !divisor_is_zero) begin
            rem_reg <= dividend;
            div_reg <= divisor << align;
            q_reg   <= '0;
            cnt_reg <= align + 1'b1;
        end else if (cnt_reg != '0) begin
            rem_reg <= r;
            q_reg   <= q[WIDTH-2:0];
            div_reg <= div_reg >> 1;
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

endmodule

// File: rtl/div_queue_unit.sv
// Queued RV32M/RV64M divide unit: sign handling and CLZ at enqueue, a small
// circular queue, a result-reuse register and sequencing of the iterative core.
module div_queue_unit
    import div_queue_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 2,
    parameter int ID_WIDTH = 3,
    parameter bit REUSE_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [2:0]          issue_fn3,
    input  logic [WIDTH-1:0]    issue_rs1,
    input  logic [WIDTH-1:0]    issue_rs2,
    input  logic [ID_WIDTH-1:0] issue_id,
    output logic                wb_done,
    output logic [WIDTH-1:0]    wb_rd,
    output logic [ID_WIDTH-1:0] wb_id,
    input  logic                wb_ack
);

    localparam int CLZ_W = $clog2(WIDTH) + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0]    a_mag;
        logic [WIDTH-1:0]    b_mag;
        logic [CLZ_W-1:0]    a_clz;
        logic [CLZ_W-1:0]    b_clz;
        logic                div_zero;
        logic                rem_op;
        logic                negate;
        logic [ID_WIDTH-1:0] id;
    } entry_t;

    function automatic logic [CLZ_W-1:0] clz_w(input logic [WIDTH-1:0] v);
        logic [6:0] c;
        c = clz64(64'(v) << (64 - WIDTH));
        if (c > 7'(WIDTH)) c = 7'(WIDTH);
        return CLZ_W'(c);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    entry_t              queue_mem [DEPTH];
    entry_t              new_entry;
    entry_t              head;
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    div_state_t          state_reg, state_next;
    logic                push, pop, take, shortcut, reuse_hit, core_start;
    logic                is_signed, rs1_neg, rs2_neg, unused_fn3;
    logic [WIDTH-1:0]    rs1_mag, rs2_mag, sel;
    logic [WIDTH-1:0]    res_q_reg, res_r_reg;
    logic                rem_op_reg, negate_reg;
    logic [ID_WIDTH-1:0] id_reg;
    logic                reuse_valid_reg;
    logic [WIDTH-1:0]    reuse_a_reg, reuse_b_reg, reuse_q_reg, reuse_r_reg;
    logic                core_done;
    logic [WIDTH-1:0]    core_q, core_r;

    assign unused_fn3 = issue_fn3[2];

    // negate_result folds in the signed qualifier, so MIN/-1 and x/0 fall out
    // of ordinary magnitude arithmetic without special cases.
    always_comb begin
        is_signed          = ~issue_fn3[FN3_UNSIGNED_BIT];
        rs1_neg            = is_signed & issue_rs1[WIDTH-1];
        rs2_neg            = is_signed & issue_rs2[WIDTH-1];
        rs1_mag            = rs1_neg ? -issue_rs1 : issue_rs1;
        rs2_mag            = rs2_neg ? -issue_rs2 : issue_rs2;
        new_entry.a_mag    = rs1_mag;
        new_entry.b_mag    = rs2_mag;
        new_entry.a_clz    = clz_w(rs1_mag);
        new_entry.b_clz    = clz_w(rs2_mag);
        new_entry.div_zero = (issue_rs2 == '0);
        new_entry.rem_op   = issue_fn3[FN3_REM_BIT];
        new_entry.negate   = issue_fn3[FN3_REM_BIT] ? rs1_neg
                                                    : ((rs1_neg ^ rs2_neg) & ~new_entry.div_zero);
        new_entry.id       = issue_id;
    end

    assign head        = queue_mem[rd_ptr_reg];
    assign issue_ready = (count_reg < CNT_W'(DEPTH));
    assign push        = issue_valid & issue_ready & ~clear;
    assign reuse_hit   = REUSE_EN && reuse_valid_reg &&
                         (head.a_mag == reuse_a_reg) && (head.b_mag == reuse_b_reg);
    assign shortcut    = head.div_zero || (head.a_clz > head.b_clz);

    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        pop        = 1'b0;
        core_start = 1'b0;
        case (state_reg)
            DIV_IDLE: take = (count_reg != '0);
            DIV_BUSY: if (core_done) state_next = DIV_DONE;
            DIV_DONE: begin
                if (wb_ack) begin
                    if (count_reg != '0) take = 1'b1;
                    else                 state_next = DIV_IDLE;
                end
            end
            default:  state_next = DIV_IDLE;
        endcase
        if (take) begin
            pop = 1'b1;
            if (reuse_hit || shortcut) begin
                state_next = DIV_DONE;
            end else begin
                state_next = DIV_BUSY;
                core_start = 1'b1;
            end
        end
        if (clear) begin
            state_next = DIV_IDLE;
            pop        = 1'b0;
            core_start = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) queue_mem[wr_ptr_reg] <= new_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= DIV_IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            res_q_reg       <= '0;
            res_r_reg       <= '0;
            rem_op_reg      <= 1'b0;
            negate_reg      <= 1'b0;
            id_reg          <= '0;
            reuse_valid_reg <= 1'b0;
            reuse_a_reg     <= '0;
            reuse_b_reg     <= '0;
            reuse_q_reg     <= '0;
            reuse_r_reg     <= '0;
        end else if (clear) begin
            state_reg       <= DIV_IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            reuse_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (!push && pop) count_reg <= count_reg - 1'b1;
            if (pop) begin
                rem_op_reg <= head.rem_op;
                negate_reg <= head.negate;
                id_reg     <= head.id;
                if (reuse_hit) begin
                    res_q_reg <= reuse_q_reg;
                    res_r_reg <= reuse_r_reg;
                end else if (shortcut) begin
                    res_q_reg <= head.div_zero ? '1 : '0;
                    res_r_reg <= head.a_mag;
                    if (REUSE_EN) begin
                        reuse_a_reg     <= head.a_mag;
                        reuse_b_reg     <= head.b_mag;
                        reuse_q_reg     <= head.div_zero ? '1 : '0;
                        reuse_r_reg     <= head.a_mag;
                        reuse_valid_reg <= 1'b1;
                    end
                end else if (REUSE_EN) begin
                    // Key is captured at start; it only becomes valid on completion.
                    reuse_a_reg     <= head.a_mag;
                    reuse_b_reg     <= head.b_mag;
                    reuse_valid_reg <= 1'b0;
                end
            end
            if (state_reg == DIV_BUSY && core_done) begin
                res_q_reg <= core_q;
                res_r_reg <= core_r;
                if (REUSE_EN) begin
                    reuse_q_reg     <= core_q;
                    reuse_r_reg     <= core_r;
                    reuse_valid_reg <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel     = rem_op_reg ? res_r_reg : res_q_reg;
        wb_rd   = negate_reg ? -sel : sel;
        wb_done = (state_reg == DIV_DONE);
        wb_id   = id_reg;
    end

    div_iterative_core #(
        .WIDTH (WIDTH),
        .CLZ_W (CLZ_W)
    ) u_core (
        .clk             (clk),
        .rst             (rst),
        .abort           (clear),
        .start           (core_start),
        .dividend        (head.a_mag),
        .divisor         (head.b_mag),
        .dividend_clz    (head.a_clz),
        .divisor_clz     (head.b_clz),
        .divisor_is_zero (head.div_zero),
        .done            (core_done),
        .q               (core_q),
        .r               (core_r)
    );

endmodule
